// File: rtl/alu_input_sequencer_if.sv
// Button inputs and ALU bank load/status outputs of the operand entry sequencer.
// The sequencer takes the slave side; whatever drives the buttons takes the master side.
interface alu_input_sequencer_if;
  logic       BTNC;
  logic       BTNL;
  logic       load_op1;
  logic       load_op2;
  logic       load_opcode;
  logic [1:0] stage;
  logic       result_valid;

  modport master (
    output BTNC, BTNL,
    input  load_op1, load_op2, load_opcode, stage, result_valid
  );

  modport slave (
    input  BTNC, BTNL,
    output load_op1, load_op2, load_opcode, stage, result_valid
  );
endinterface

// File: rtl/alu_input_sequencer.sv
// Debounces the enter/back buttons and steps OP1 -> OP2 -> OPCODE -> RESULT,
// issuing one-cycle load strobes to the ALU operand/opcode registers.
module alu_input_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic                 CLK100MHZ,
  input  logic                 CPU_RESETN,
  alu_input_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_OP1    = 2'd0,
    S_OP2    = 2'd1,
    S_OPCODE = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  // Index 0 is enter (BTNC), index 1 is back (BTNL).
  logic [1:0]       btn_raw;
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       lvl_q, lvl_d;
  logic [1:0]       prev_q, prev_d;
  logic [1:0]       rise_q, rise_d;
  logic [1:0]       evt_q, evt_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  state_t state_q, state_d;
  logic   result_valid_q, result_valid_d;
  logic   enter_evt, back_evt;

  assign btn_raw = {bus.BTNL, bus.BTNC};

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    lvl_d   = lvl_q;
    prev_d  = lvl_q;
    rise_d  = lvl_q & ~prev_q;
    // The extra event stage fixes press-to-event latency at DEBOUNCE_CYCLES+3 edges.
    evt_d   = rise_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          lvl_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      prev_q  <= '0;
      rise_q  <= '0;
      evt_q   <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      lvl_q   <= lvl_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
      evt_q   <= evt_d;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Enter has priority: a coincident back event is discarded.
  assign enter_evt = evt_q[0];
  assign back_evt  = evt_q[1] & ~evt_q[0];

  always_comb begin
    state_d         = state_q;
    bus.load_op1    = 1'b0;
    bus.load_op2    = 1'b0;
    bus.load_opcode = 1'b0;
    case (state_q)
      S_OP1: begin
        if (enter_evt) begin
          bus.load_op1 = 1'b1;
          state_d      = S_OP2;
        end
      end
      S_OP2: begin
        if (enter_evt) begin
          bus.load_op2 = 1'b1;
          state_d      = S_OPCODE;
        end else if (back_evt) begin
          state_d = S_OP1;
        end
      end
      S_OPCODE: begin
        if (enter_evt) begin
          bus.load_opcode = 1'b1;
          state_d         = S_RESULT;
        end else if (back_evt) begin
          state_d = S_OP2;
        end
      end
      S_RESULT: begin
        if (enter_evt) begin
          state_d = S_OP1;
        end else if (back_evt) begin
          state_d = S_OPCODE;
        end
      end
      default: state_d = S_OP1;
    endcase
    result_valid_d = (state_d == S_RESULT);
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q        <= S_OP1;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign bus.stage        = state_q;
  assign bus.result_valid = result_valid_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed bench for alu_input_sequencer with DEBOUNCE_CYCLES=4: strobes are
// scoreboarded by exact cycle, stage/result_valid are checked after each step.
module tb_alu_input_sequencer;

  localparam int DEB = 4;
  localparam int LAT = DEB + 4; // drive at a negedge -> strobe seen at negedge LAT cycles later
  localparam int W   = 19;      // {cycle[15:0], strobes[2:0]}

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  logic [W-1:0] exp_q[$];

  alu_input_sequencer_if bus ();

  alu_input_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3)
  ) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .bus       (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard monitor ----------------
  logic [2:0]   strobes;
  logic [W-1:0] exp_item;
  logic [W-1:0] act_item;
  assign strobes = {bus.load_opcode, bus.load_op2, bus.load_op1};

  always @(negedge clk) begin
    if (strobes != 3'b000) begin
      act_item = {cyc[15:0], strobes};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got strobes=%b at cycle %0d, required none", strobes, cyc);
      end else begin
        exp_item = exp_q.pop_front();
        if (act_item != exp_item) begin
          errors++;
          $display("FAIL strobe: got cycle=%0d strobes=%b, required cycle=%0d strobes=%b",
                   cyc, strobes, exp_item[W-1:3], exp_item[2:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_strobe(input logic [2:0] s);
    logic [15:0] c;
    c = 16'(cyc + LAT);
    exp_q.push_back({c, s});
  endtask

  task automatic check_status(input string name, input logic [1:0] exp_stage, input logic exp_rv);
    checks++;
    if (bus.stage !== exp_stage || bus.result_valid !== exp_rv) begin
      errors++;
      $display("FAIL %s: got stage=%0d result_valid=%b, required stage=%0d result_valid=%b",
               name, bus.stage, bus.result_valid, exp_stage, exp_rv);
    end
  endtask

  task automatic check_no_strobe(input string name);
    checks++;
    if (strobes !== 3'b000) begin
      errors++;
      $display("FAIL %s: got strobes=%b, required 000", name, strobes);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Press with given buttons for `hold` cycles, then release and let the release debounce.
  task automatic press(input logic c, input logic l, input logic [2:0] exp_s, input int hold);
    @(negedge clk);
    bus.BTNC = c;
    bus.BTNL = l;
    if (exp_s != 3'b000) expect_strobe(exp_s);
    repeat (hold) @(negedge clk);
    bus.BTNC = 1'b0;
    bus.BTNL = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    bus.BTNC = 1'b0;
    bus.BTNL = 1'b0;
    #1;
    check_status("reset_state", 2'd0, 1'b0);
    check_no_strobe("reset_strobes");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: held enter -> one load_op1 at fixed latency, none while held
    press(1'b1, 1'b0, 3'b001, 20);
    check_status("held_enter_stage", 2'd1, 1'b0);

    // 2: full sequence then wrap from RESULT
    do_reset();
    press(1'b1, 1'b0, 3'b001, 12);
    check_status("seq_op2", 2'd1, 1'b0);
    press(1'b1, 1'b0, 3'b010, 12);
    check_status("seq_opcode", 2'd2, 1'b0);
    press(1'b1, 1'b0, 3'b100, 12);
    check_status("seq_result", 2'd3, 1'b1);
    press(1'b1, 1'b0, 3'b000, 12);
    check_status("seq_wrap", 2'd0, 1'b0);

    // 3: bounce never stable long enough
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.BTNC = (k % 2 == 0);
      @(negedge clk);
    end
    bus.BTNC = 1'b0;
    repeat (12) @(negedge clk);
    check_status("bounce_stage", 2'd0, 1'b0);

    // 4: back from OPCODE, then back in OP1 stays
    press(1'b1, 1'b0, 3'b001, 12);
    press(1'b1, 1'b0, 3'b010, 12);
    check_status("back_pre", 2'd2, 1'b0);
    press(1'b0, 1'b1, 3'b000, 12);
    check_status("back_opcode", 2'd1, 1'b0);
    press(1'b0, 1'b1, 3'b000, 12);
    check_status("back_op2", 2'd0, 1'b0);
    press(1'b0, 1'b1, 3'b000, 12);
    check_status("back_op1_stay", 2'd0, 1'b0);

    // 5: simultaneous enter/back in OP2 -> enter wins
    press(1'b1, 1'b0, 3'b001, 12);
    press(1'b1, 1'b1, 3'b010, 12);
    check_status("simultaneous", 2'd2, 1'b0);

    // 6a: reset mid-debounce, button still held afterwards
    @(negedge clk);
    bus.BTNC = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_status("rst_mid_deb", 2'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_strobe(3'b001);
    repeat (15) @(negedge clk);
    check_status("rst_mid_deb_fresh", 2'd1, 1'b0);
    bus.BTNC = 1'b0;
    repeat (10) @(negedge clk);

    // 6b: reset during the event cycle drops the strobe
    @(negedge clk);
    bus.BTNC = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_no_strobe("rst_evt_drop");
    check_status("rst_evt_stage", 2'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expect_strobe(3'b001);
    repeat (15) @(negedge clk);
    check_status("rst_evt_fresh", 2'd1, 1'b0);
    bus.BTNC = 1'b0;
    repeat (10) @(negedge clk);

    // ---------------- final report ----------------
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_strobes: got %0d outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
